// File: rtl/alu_acc.sv
// Clocked accumulator ALU: single-cycle ops retire on the issuing edge, MUL
// runs as a WIDTH-cycle shift-add under a start/busy/done handshake.
module alu_acc #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       opcode,
   input  logic [WIDTH-1:0] mdr,
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] ac,
   output logic             nflg,
   output logic             zflg,
   output logic             cflg,
   output logic             vflg,
   output logic             busy,
   output logic             done
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW:0] CNT_INIT = WIDTH[SHW:0];
   localparam logic [SHW:0] CNT_ONE  = 1;

   localparam logic [7:0] OP_LOAD  = 8'h01;
   localparam logic [7:0] OP_LOADI = 8'h02;
   localparam logic [7:0] OP_CLR   = 8'h04;
   localparam logic [7:0] OP_ADD   = 8'h05;
   localparam logic [7:0] OP_ADDI  = 8'h06;
   localparam logic [7:0] OP_SUBT  = 8'h07;
   localparam logic [7:0] OP_SUBTI = 8'h08;
   localparam logic [7:0] OP_NEG   = 8'h09;
   localparam logic [7:0] OP_NOT   = 8'h0A;
   localparam logic [7:0] OP_AND   = 8'h0B;
   localparam logic [7:0] OP_OR    = 8'h0C;
   localparam logic [7:0] OP_XOR   = 8'h0D;
   localparam logic [7:0] OP_SHL   = 8'h0E;
   localparam logic [7:0] OP_SHR   = 8'h0F;
   localparam logic [7:0] OP_MUL   = 8'h10;
   localparam logic [7:0] OP_ROL   = 8'h11;
   localparam logic [7:0] OP_ROR   = 8'h12;
   localparam logic [7:0] OP_ASR   = 8'h13;

   typedef enum logic {IDLE, MUL} state_t;

   state_t                   state;
   logic [SHW:0]             cnt;
   logic [2*WIDTH-1:0]       mcand;
   logic [WIDTH-1:0]         mplier;
   logic [2*WIDTH-1:0]       prod;
   logic [2*WIDTH-1:0]       prod_nx;

   logic [SHW-1:0]           sh;
   logic [WIDTH-1:0]         opb;
   logic signed [2*WIDTH-1:0] acx;
   logic [2*WIDTH-1:0]       t;
   logic [WIDTH:0]           sum;
   logic [WIDTH-1:0]         res;
   logic                     cres;
   logic                     vres;
   logic                     wr;
   logic                     is_mul;

   assign sh      = value[SHW-1:0];
   assign opb     = (opcode == OP_ADD || opcode == OP_SUBT) ? mdr : value;
   assign acx     = {ac, {WIDTH{1'b0}}};
   assign is_mul  = (opcode == OP_MUL);
   assign prod_nx = mplier[0] ? prod + mcand : prod;

   // Single-cycle result and flag candidates; shifts and rotates go through a
   // double-width temporary so the bit shifted or rotated out falls at a fixed index.
   always_comb begin
      res  = ac;
      cres = 1'b0;
      vres = 1'b0;
      wr   = 1'b1;
      t    = '0;
      sum  = '0;
      case (opcode)
         OP_LOAD:  res = mdr;
         OP_LOADI: res = value;
         OP_CLR:   res = '0;
         OP_ADD, OP_ADDI: begin
            sum  = {1'b0, ac} + {1'b0, opb};
            res  = sum[WIDTH-1:0];
            cres = sum[WIDTH];
            vres = (ac[WIDTH-1] == opb[WIDTH-1]) && (res[WIDTH-1] != ac[WIDTH-1]);
         end
         OP_SUBT, OP_SUBTI: begin
            sum  = {1'b0, ac} - {1'b0, opb};
            res  = sum[WIDTH-1:0];
            cres = sum[WIDTH];
            vres = (ac[WIDTH-1] != opb[WIDTH-1]) && (res[WIDTH-1] != ac[WIDTH-1]);
         end
         OP_NEG: begin
            res  = '0 - mdr;
            vres = (mdr == {1'b1, {(WIDTH-1){1'b0}}});
         end
         OP_NOT: res = ~mdr;
         OP_AND: res = ac & mdr;
         OP_OR:  res = ac | mdr;
         OP_XOR: res = ac ^ mdr;
         OP_SHL: begin
            t    = {{WIDTH{1'b0}}, ac} << sh;
            res  = t[WIDTH-1:0];
            cres = t[WIDTH];
         end
         OP_SHR: begin
            t    = {ac, {WIDTH{1'b0}}} >> sh;
            res  = t[2*WIDTH-1:WIDTH];
            cres = t[WIDTH-1];
         end
         OP_ASR: begin
            t    = acx >>> sh;
            res  = t[2*WIDTH-1:WIDTH];
            cres = t[WIDTH-1];
         end
         OP_ROL: begin
            t    = {ac, ac} << sh;
            res  = t[2*WIDTH-1:WIDTH];
            cres = (sh != '0) & res[0];
         end
         OP_ROR: begin
            t    = {ac, ac} >> sh;
            res  = t[WIDTH-1:0];
            cres = (sh != '0) & res[WIDTH-1];
         end
         default: wr = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         ac    <= '0;
         nflg  <= 1'b0;
         zflg  <= 1'b1;
         cflg  <= 1'b0;
         vflg  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (is_mul) begin
                     cnt   <= CNT_INIT;
                     busy  <= 1'b1;
                     state <= MUL;
                  end else begin
                     done <= 1'b1;
                     if (wr) begin
                        ac   <= res;
                        nflg <= res[WIDTH-1];
                        zflg <= (res == '0);
                        cflg <= cres;
                        vflg <= vres;
                     end
                  end
               end
            end
            MUL: begin
               cnt <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  ac    <= prod_nx[WIDTH-1:0];
                  nflg  <= prod_nx[WIDTH-1];
                  zflg  <= (prod_nx[WIDTH-1:0] == '0);
                  cflg  <= |prod_nx[2*WIDTH-1:WIDTH];
                  vflg  <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   // Multiplier datapath carries no reset; it is fully reloaded on every MUL issue.
   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         if (start && is_mul) begin
            mcand  <= {{WIDTH{1'b0}}, mdr};
            mplier <= ac;
            prod   <= '0;
         end
      end else begin
         prod   <= prod_nx;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end
endmodule

// File: tb/tb_alu_acc.sv
// Directed bench for alu_acc (WIDTH=8): reset, arithmetic, shifts, MUL handshake,
// start-while-busy and asynchronous reset during MUL.
module tb_alu_acc;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] opcode = 8'h00;
   logic [7:0] mdr = 8'h00;
   logic [7:0] value = 8'h00;
   logic [7:0] ac;
   logic       nflg, zflg, cflg, vflg, busy, done;

   int tests = 0;
   int fails = 0;

   alu_acc #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
      .mdr(mdr), .value(value), .ac(ac), .nflg(nflg), .zflg(zflg),
      .cflg(cflg), .vflg(vflg), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic drive(input logic [7:0] op, input logic [7:0] m, input logic [7:0] v);
      start  = 1'b1;
      opcode = op;
      mdr    = m;
      value  = v;
   endtask

   // Waits (bounded) for busy to fall; reports cycles spent busy and whether ac held.
   task automatic wait_mul(input logic [7:0] hold, output int n, output bit held);
      n = 0;
      held = 1'b1;
      while (busy && n < 20) begin
         if (ac !== hold) held = 1'b0;
         n++;
         tick();
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      tests++;
      if ({ac, nflg, zflg, cflg, vflg, busy, done} !== {8'h00, 4'b0100, 2'b00}) begin
         fails++;
         $display("FAIL reset: got %b want %b", {ac, nflg, zflg, cflg, vflg, busy, done},
                  {8'h00, 4'b0100, 2'b00});
      end
   endtask

   task automatic test_add_overflow;
      drive(8'h02, 8'h00, 8'h7F);
      tick();
      tests++;
      if ({ac, nflg, zflg, cflg, vflg, done} !== {8'h7F, 4'b0000, 1'b1}) begin
         fails++; $display("FAIL loadi_7f: got %b want %b", {ac, nflg, zflg, cflg, vflg, done}, {8'h7F, 4'b0000, 1'b1});
      end
      drive(8'h06, 8'h00, 8'h01);
      tick();
      start = 1'b0;
      tests++;
      if ({ac, nflg, zflg, cflg, vflg, done} !== {8'h80, 4'b1001, 1'b1}) begin
         fails++; $display("FAIL addi_ovf: got %b want %b", {ac, nflg, zflg, cflg, vflg, done}, {8'h80, 4'b1001, 1'b1});
      end
      tick();
      tests++;
      if (done !== 1'b0) begin
         fails++; $display("FAIL done_drop: got %b want 0", done);
      end
   endtask

   task automatic test_sub_neg;
      drive(8'h04, 8'h00, 8'h00);
      tick();
      tests++;
      if ({ac, nflg, zflg, cflg, vflg, done} !== {8'h00, 4'b0100, 1'b1}) begin
         fails++; $display("FAIL clr: got %b want %b", {ac, nflg, zflg, cflg, vflg, done}, {8'h00, 4'b0100, 1'b1});
      end
      drive(8'h08, 8'h00, 8'h01);
      tick();
      tests++;
      if ({ac, nflg, zflg, cflg, vflg, done} !== {8'hFF, 4'b1010, 1'b1}) begin
         fails++; $display("FAIL subti_borrow: got %b want %b", {ac, nflg, zflg, cflg, vflg, done}, {8'hFF, 4'b1010, 1'b1});
      end
      drive(8'h09, 8'h80, 8'h00);
      tick();
      start = 1'b0;
      tests++;
      if ({ac, nflg, zflg, cflg, vflg, done} !== {8'h80, 4'b1001, 1'b1}) begin
         fails++; $display("FAIL neg_min: got %b want %b", {ac, nflg, zflg, cflg, vflg, done}, {8'h80, 4'b1001, 1'b1});
      end
   endtask

   task automatic test_mul;
      int  n;
      bit  held;
      drive(8'h02, 8'h00, 8'h0D);
      tick();
      drive(8'h10, 8'h0B, 8'h00);
      tick();
      start = 1'b0;
      wait_mul(8'h0D, n, held);
      tests++;
      if (n !== 8) begin
         fails++; $display("FAIL mul_busy_cycles: got %0d want 8", n);
      end
      tests++;
      if (!held) begin
         fails++; $display("FAIL mul_ac_hold: ac changed while busy, want 0d");
      end
      tests++;
      if ({ac, nflg, zflg, cflg, vflg, done} !== {8'h8F, 4'b1000, 1'b1}) begin
         fails++; $display("FAIL mul_0d_0b: got %b want %b", {ac, nflg, zflg, cflg, vflg, done}, {8'h8F, 4'b1000, 1'b1});
      end
      drive(8'h02, 8'h00, 8'h10);
      tick();
      drive(8'h10, 8'h20, 8'h00);
      tick();
      start = 1'b0;
      wait_mul(8'h10, n, held);
      tests++;
      if ({ac, nflg, zflg, cflg, vflg, done} !== {8'h00, 4'b0110, 1'b1}) begin
         fails++; $display("FAIL mul_carry: got %b want %b", {ac, nflg, zflg, cflg, vflg, done}, {8'h00, 4'b0110, 1'b1});
      end
   endtask

   task automatic test_shift_rotate;
      drive(8'h02, 8'h00, 8'h31);
      tick();
      drive(8'h0E, 8'h00, 8'h03);
      tick();
      tests++;
      if ({ac, nflg, zflg, cflg, vflg, done} !== {8'h88, 4'b1010, 1'b1}) begin
         fails++; $display("FAIL shl3: got %b want %b", {ac, nflg, zflg, cflg, vflg, done}, {8'h88, 4'b1010, 1'b1});
      end
      drive(8'h13, 8'h00, 8'h02);
      tick();
      tests++;
      if ({ac, nflg, zflg, cflg, vflg, done} !== {8'hE2, 4'b1000, 1'b1}) begin
         fails++; $display("FAIL asr2: got %b want %b", {ac, nflg, zflg, cflg, vflg, done}, {8'hE2, 4'b1000, 1'b1});
      end
      drive(8'h12, 8'h00, 8'h01);
      tick();
      tests++;
      if ({ac, nflg, zflg, cflg, vflg, done} !== {8'h71, 4'b0000, 1'b1}) begin
         fails++; $display("FAIL ror1: got %b want %b", {ac, nflg, zflg, cflg, vflg, done}, {8'h71, 4'b0000, 1'b1});
      end
      drive(8'h02, 8'h00, 8'h81);
      tick();
      drive(8'h11, 8'h00, 8'h01);
      tick();
      tests++;
      if ({ac, nflg, zflg, cflg, vflg, done} !== {8'h03, 4'b0010, 1'b1}) begin
         fails++; $display("FAIL rol1: got %b want %b", {ac, nflg, zflg, cflg, vflg, done}, {8'h03, 4'b0010, 1'b1});
      end
      drive(8'h00, 8'hAA, 8'h55);
      tick();
      tests++;
      if ({ac, nflg, zflg, cflg, vflg, done} !== {8'h03, 4'b0010, 1'b1}) begin
         fails++; $display("FAIL nop_hold: got %b want %b", {ac, nflg, zflg, cflg, vflg, done}, {8'h03, 4'b0010, 1'b1});
      end
      drive(8'h0D, 8'hFF, 8'h00);
      tick();
      start = 1'b0;
      tests++;
      if ({ac, nflg, zflg, cflg, vflg, done} !== {8'hFC, 4'b1000, 1'b1}) begin
         fails++; $display("FAIL xor_ff: got %b want %b", {ac, nflg, zflg, cflg, vflg, done}, {8'hFC, 4'b1000, 1'b1});
      end
   endtask

   task automatic test_start_while_busy;
      int  n;
      bit  held;
      drive(8'h02, 8'h00, 8'h03);
      tick();
      drive(8'h10, 8'h05, 8'h00);
      tick();
      drive(8'h02, 8'h00, 8'h55);
      tick();
      start = 1'b0;
      wait_mul(8'h03, n, held);
      tests++;
      if (n !== 7 || !held) begin
         fails++; $display("FAIL busy_ignore_timing: got n=%0d held=%0d want n=7 held=1", n, held);
      end
      tests++;
      if ({ac, nflg, zflg, cflg, vflg, done} !== {8'h0F, 4'b0000, 1'b1}) begin
         fails++; $display("FAIL busy_ignore_result: got %b want %b", {ac, nflg, zflg, cflg, vflg, done}, {8'h0F, 4'b0000, 1'b1});
      end
      tick();
      tests++;
      if ({ac, done, busy} !== {8'h0F, 2'b00}) begin
         fails++; $display("FAIL busy_no_queue: got %b want %b", {ac, done, busy}, {8'h0F, 2'b00});
      end
   endtask

   task automatic test_reset_mid_mul;
      bit seen;
      drive(8'h02, 8'h00, 8'h07);
      tick();
      drive(8'h10, 8'h03, 8'h00);
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({ac, nflg, zflg, cflg, vflg, busy, done} !== {8'h00, 4'b0100, 2'b00}) begin
         fails++; $display("FAIL async_reset: got %b want %b", {ac, nflg, zflg, cflg, vflg, busy, done},
                           {8'h00, 4'b0100, 2'b00});
      end
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done || busy || ac !== 8'h00) seen = 1'b1;
         tick();
      end
      tests++;
      if (seen) begin
         fails++; $display("FAIL reset_discard: got activity after reset want none (ac=%h)", ac);
      end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_sub_neg();
      test_mul();
      test_shift_rotate();
      test_start_while_busy();
      test_reset_mid_mul();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_acc.md
# alu_acc

Parametrised, clocked successor to the 8-bit combinational ALU. It holds its own accumulator and registered N/Z/C/V flags, and accepts one operation per start pulse. Single-cycle ops complete in one clock; MUL runs as an iterative shift-add over WIDTH cycles under a start/busy/done handshake. It sits between the control unit, which issues opcode/start, and the datapath, which provides mdr and value.

## Interface
- WIDTH, default 8: data width. Must be a power of two, at least 4.
- SHW, derived as $clog2(WIDTH): shift-count width. Local only, not overridable.

- clk  input  1  single clock. All state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  issue request. Sampled only when busy=0.
- opcode  input  8  operation code, sampled with start.
- mdr  input  WIDTH  memory operand, sampled with start.
- value  input  WIDTH  immediate operand, sampled with start.
- ac  output  WIDTH  accumulator, registered.
- nflg, zflg, cflg, vflg  output  1 each  negative, zero, carry/borrow and signed-overflow flags, registered.
- busy  output  1  high while MUL is in progress.
- done  output  1  one-cycle pulse when a result (or NOP) retires.

## Operation
- **Opcodes (unchanged encodings):**
  - 01 LOAD: ac=mdr. 02 LOADI: ac=value. 04 CLR: ac=0.
  - 05 ADD: ac+mdr. 06 ADDI: ac+value. 07 SUBT: ac-mdr. 08 SUBTI: ac-value.
  - 09 NEG: -mdr. 0A NOT: ~mdr.
  - 0B AND, 0C OR, 0D XOR: ac op mdr.
  - 0E SHL, 0F SHR (logical): ac shifted by value[SHW-1:0].
- **New opcodes:**
  - 10 MUL: unsigned ac*mdr; low WIDTH bits kept. Multi-cycle.
  - 11 ROL, 12 ROR: rotate ac by value[SHW-1:0].
  - 13 ASR: arithmetic right shift of ac by value[SHW-1:0].
- **Other opcodes (including 00):** NOP. ac and flags unchanged; done still pulses.
- **Flags** are written only on retirement of a non-NOP op.
  - nflg = result[WIDTH-1]; zflg = (result==0).
  - cflg:
    - ADD/ADDI: carry out.
    - SUBT/SUBTI: borrow, i.e. unsigned ac < operand.
    - SHL/SHR/ASR: last bit shifted out; 0 if count is 0.
    - ROL/ROR: the bit rotated into the vacated end; 0 if count is 0.
    - MUL: 1 if high WIDTH bits of the 2*WIDTH product are nonzero.
    - All others: 0.
  - vflg:
    - ADD/ADDI/SUBT/SUBTI: two's-complement overflow.
    - NEG: 1 when mdr is the most-negative value.
    - All others: 0.
- **All arithmetic** is WIDTH bits, two's complement. C and V are computed from a WIDTH+1 intermediate.
- **State machine:**
  - IDLE: on start with opcode 10, latch mdr as multiplicand and ac as multiplier, clear the 2*WIDTH product, load counter=WIDTH, go to MUL. Any other opcode retires in the same edge and stays in IDLE.
  - MUL: each cycle, if the multiplier LSB is 1, add the shifted multiplicand to the product; shift; decrement the counter. When the counter reaches 1, write ac and flags and go to IDLE.
- **Start while busy=1** is ignored entirely: no queuing, no effect on the operation in flight.

## Timing
- **Reset values:** ac=0, nflg=0, zflg=1, cflg=0, vflg=0, busy=0, done=0, state=IDLE.
- **Single-cycle op:** start sampled high at edge k. ac and flags take the new values at edge k, and done=1 for the cycle following edge k. Back-to-back starts on every cycle are legal; each sees the ac written by the previous op.
- **MUL:** start at edge k. busy=1 from edge k through edge k+WIDTH-1. ac and flags are written at edge k+WIDTH, busy drops and done=1 at the same edge, for one cycle.
  - The next start is accepted at edge k+WIDTH+1 at the earliest.
  - ac holds its pre-MUL value while busy=1.
- **Reset mid-operation:** rst_n low at any time forces all reset values immediately, asynchronously. The in-flight MUL is discarded.
- **mdr/value** need only be valid in the start cycle.

## Test plan
- Reset pulse, then idle: ac=0x00, zflg=1, all other flags 0, busy=0, done=0.
- LOADI 0x7F, then ADDI 0x01 on consecutive cycles (WIDTH=8): ac=0x80, N=1, V=1, C=0, Z=0; done pulses twice.
- CLR, then SUBTI 0x01: ac=0xFF, N=1, C=1, V=0. Then NEG with mdr=0x80: ac=0x80, V=1.
- LOADI 0x0D, then MUL with mdr=0x0B: busy high 8 cycles, ac=0x8F, C=0. Then LOADI 0x10, MUL with mdr=0x20: ac=0x00, Z=1, C=1.
- LOADI 0x31, SHL value=3: ac=0x88, C=1. Then ASR value=2: ac=0xE2, N=1, C=0. Then ROR value=1: ac=0x71, C=0.
- Start MUL; pulse start with LOADI 0x55 during busy: ignored, MUL result correct. Start MUL again and assert rst_n=0 at cycle 4: ac=0, busy=0 immediately, no done pulse.
